// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
// The state enum is also exported on the debug port so checkers can bind to it.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } ctrl_state_t;

    // Stage control bundle for datapath wiring.
    typedef struct packed {
        logic hold_if;
        logic hold_id;
        logic hold_ex;
        logic hold_mem;
        logic flush_id;
        logic flush_ex;
        logic bubble_wb;
    } haz_ctrl_t;

    function automatic logic any_hold(input haz_ctrl_t c);
        return c.hold_if | c.hold_id | c.hold_ex | c.hold_mem;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: flags a decode operand that depends on a load sitting in EX.
// x0 is never a real dependency, so ex_rd == 0 cannot stall.
module pipeline_ctrl_hazard_detect (
    input  logic       id_valid,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);
    assign load_use_o = id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0)
                        && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: dbus wait stalls,
// branch/jump redirects (draining an in-flight fetch first) and load-use stalls.
import pipeline_ctrl_pkg::*;

module pipeline_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ibus_inflight,
    input  logic             ibus_data_ok,
    input  logic             dbus_busy,
    output logic             hold_if,
    output logic             hold_id,
    output logic             hold_ex,
    output logic             hold_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             bubble_wb,
    output logic             fetch_kill,
    output logic             pc_load,
    output logic [XLEN-1:0]  pc_target,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt,
    output ctrl_state_t      dbg_state_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ctrl_state_t      state_q, state_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] redirect_cnt_q;

    haz_ctrl_t ctrl;
    logic      load_use;
    logic      redir_acc;
    logic      fetch_kill_c;
    logic      pc_load_c;

    pipeline_ctrl_hazard_detect u_hazard_detect (
        .id_valid   (id_valid),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .load_use_o (load_use)
    );

    // Priority: dbus wait freezes everything, then redirect, then load-use.
    always_comb begin
        ctrl         = '0;
        fetch_kill_c = 1'b0;
        pc_load_c    = 1'b0;
        redir_acc    = 1'b0;
        state_d      = state_q;
        target_d     = target_q;
        if (dbus_busy) begin
            ctrl.hold_if   = 1'b1;
            ctrl.hold_id   = 1'b1;
            ctrl.hold_ex   = 1'b1;
            ctrl.hold_mem  = 1'b1;
            ctrl.bubble_wb = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_redirect && ex_valid) begin
                        redir_acc     = 1'b1;
                        target_d      = ex_target;
                        ctrl.flush_id = 1'b1;
                        ctrl.flush_ex = 1'b1;
                        fetch_kill_c  = ibus_data_ok;
                        state_d       = (ibus_inflight && !ibus_data_ok) ? DRAIN : REDIRECT;
                    end else if (load_use) begin
                        ctrl.hold_if  = 1'b1;
                        ctrl.hold_id  = 1'b1;
                        ctrl.flush_ex = 1'b1;
                    end
                end
                DRAIN: begin
                    ctrl.flush_id = 1'b1;
                    if (ex_redirect && ex_valid) begin
                        redir_acc     = 1'b1;
                        target_d      = ex_target;
                        ctrl.flush_ex = 1'b1;
                    end
                    if (ibus_data_ok) begin
                        fetch_kill_c = 1'b1;
                        state_d      = REDIRECT;
                    end
                end
                REDIRECT: begin
                    pc_load_c     = 1'b1;
                    ctrl.flush_id = 1'b1;
                    state_d       = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RUN;
            target_q       <= '0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            if (any_hold(ctrl) && (stall_cnt_q != CNT_MAX))
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (redir_acc && (redirect_cnt_q != CNT_MAX))
                redirect_cnt_q <= redirect_cnt_q + CNT_ONE;
        end
    end

    assign hold_if      = ctrl.hold_if;
    assign hold_id      = ctrl.hold_id;
    assign hold_ex      = ctrl.hold_ex;
    assign hold_mem     = ctrl.hold_mem;
    assign flush_id     = ctrl.flush_id;
    assign flush_ex     = ctrl.flush_ex;
    assign bubble_wb    = ctrl.bubble_wb;
    assign fetch_kill   = fetch_kill_c;
    assign pc_load      = pc_load_c;
    assign pc_target    = target_q;
    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: inputs change #1 after posedge,
// outputs are sampled on the negedge. Redirect targets go through exp_q.
import pipeline_ctrl_pkg::*;

module tb_pipeline_ctrl;

    localparam int XLEN  = 64;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_use_rs1, id_use_rs2;
    logic [4:0]       id_rs1, id_rs2;
    logic             ex_valid, ex_is_load;
    logic [4:0]       ex_rd;
    logic             ex_redirect;
    logic [XLEN-1:0]  ex_target;
    logic             ibus_inflight, ibus_data_ok, dbus_busy;
    logic             hold_if, hold_id, hold_ex, hold_mem;
    logic             flush_id, flush_ex, bubble_wb, fetch_kill, pc_load;
    logic [XLEN-1:0]  pc_target;
    logic [CNT_W-1:0] stall_cnt, redirect_cnt;
    ctrl_state_t      dbg_state;

    logic [XLEN-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int exp_stall;

    always #5 clk = ~clk;

    pipeline_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .ibus_inflight(ibus_inflight), .ibus_data_ok(ibus_data_ok), .dbus_busy(dbus_busy),
        .hold_if(hold_if), .hold_id(hold_id), .hold_ex(hold_ex), .hold_mem(hold_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .bubble_wb(bubble_wb),
        .fetch_kill(fetch_kill), .pc_load(pc_load), .pc_target(pc_target),
        .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt), .dbg_state_o(dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_redirect = 0; ex_target = '0;
        ibus_inflight = 0; ibus_data_ok = 0; dbus_busy = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic drive_redirect(input logic [XLEN-1:0] tgt);
        ex_valid = 1; ex_redirect = 1; ex_target = tgt;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #1;
        n_checks++;
        if ({hold_if, hold_id, hold_ex, hold_mem, flush_id, flush_ex, bubble_wb, fetch_kill, pc_load} !== 9'b0)
            $display("FAIL reset_outputs got %b exp 0",
                     {hold_if, hold_id, hold_ex, hold_mem, flush_id, flush_ex, bubble_wb, fetch_kill, pc_load});
        else n_pass++;
        n_checks++;
        if ({pc_target, stall_cnt, redirect_cnt} !== '0 || dbg_state !== RUN)
            $display("FAIL reset_regs got tgt=%h stall=%0d redir=%0d st=%0d exp 0/0/0/RUN",
                     pc_target, stall_cnt, redirect_cnt, dbg_state);
        else n_pass++;
    endtask

    task automatic test_load_use();
        logic exp_lu;
        reset_dut();
        exp_stall = 0;
        // lw x5 in EX, ID reads rs2 = x5
        id_valid = 1; id_use_rs2 = 1; id_rs2 = 5; ex_valid = 1; ex_is_load = 1; ex_rd = 5;
        @(negedge clk);
        n_checks++;
        if ({hold_if, hold_id, flush_ex, hold_ex, hold_mem, flush_id, bubble_wb} !== 7'b1110000)
            $display("FAIL load_use_stall got %b exp 1110000",
                     {hold_if, hold_id, flush_ex, hold_ex, hold_mem, flush_id, bubble_wb});
        else n_pass++;
        exp_stall++;
        next_cycle();
        ex_valid = 0; ex_is_load = 0;  // bubble now in EX
        @(negedge clk);
        n_checks++;
        if ({hold_if, hold_id, flush_ex} !== 3'b000)
            $display("FAIL load_use_one_cycle got %b exp 000", {hold_if, hold_id, flush_ex});
        else n_pass++;
        next_cycle();
        idle_inputs();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 0; ex_valid = 1; ex_is_load = 1; ex_rd = 0;
        @(negedge clk);
        n_checks++;
        if ({hold_if, hold_id, flush_ex} !== 3'b000)
            $display("FAIL load_use_x0 got %b exp 000", {hold_if, hold_id, flush_ex});
        else n_pass++;
        // random sweep over a small register window to get frequent matches
        for (int i = 0; i < 24; i++) begin
            next_cycle();
            id_valid   = 1'($urandom_range(0, 1));
            id_use_rs1 = 1'($urandom_range(0, 1));
            id_use_rs2 = 1'($urandom_range(0, 1));
            id_rs1     = 5'($urandom_range(0, 3));
            id_rs2     = 5'($urandom_range(0, 3));
            ex_valid   = 1'($urandom_range(0, 1));
            ex_is_load = 1'($urandom_range(0, 1));
            ex_rd      = 5'($urandom_range(0, 3));
            exp_lu = id_valid && ex_valid && ex_is_load && (ex_rd != 0) &&
                     ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            @(negedge clk);
            n_checks++;
            if ({hold_if, hold_id, flush_ex} !== {3{exp_lu}})
                $display("FAIL load_use_rand[%0d] got %b exp %b", i, {hold_if, hold_id, flush_ex}, {3{exp_lu}});
            else n_pass++;
            if (exp_lu) exp_stall++;
        end
        next_cycle();
        idle_inputs();
        n_checks++;
        if (stall_cnt !== CNT_W'(exp_stall))
            $display("FAIL stall_cnt_load_use got %0d exp %0d", stall_cnt, exp_stall);
        else n_pass++;
    endtask

    task automatic test_redirect_idle();
        logic [XLEN-1:0] exp_t;
        reset_dut();
        drive_redirect(64'h0000_0000_8000_0100);
        exp_q.push_back(64'h0000_0000_8000_0100);
        @(negedge clk);
        n_checks++;
        if ({flush_id, flush_ex, pc_load, fetch_kill} !== 4'b1100)
            $display("FAIL redir_idle_accept got %b exp 1100", {flush_id, flush_ex, pc_load, fetch_kill});
        else n_pass++;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (pc_load !== 1'b1 || flush_id !== 1'b1)
            $display("FAIL redir_idle_pc_load got pc_load=%b flush_id=%b exp 1/1", pc_load, flush_id);
        else n_pass++;
        if (pc_load === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL redir_idle_target got pc_load exp no pending target");
            else begin
                exp_t = exp_q.pop_front();
                if (pc_target !== exp_t) $display("FAIL redir_idle_target got %h exp %h", pc_target, exp_t);
                else n_pass++;
            end
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (redirect_cnt !== 1 || pc_load !== 1'b0 || dbg_state !== RUN)
            $display("FAIL redir_idle_after got cnt=%0d pc_load=%b st=%0d exp 1/0/RUN",
                     redirect_cnt, pc_load, dbg_state);
        else n_pass++;
    endtask

    task automatic test_redirect_inflight();
        int drain_cycles;
        int wait_cycles;
        logic [XLEN-1:0] exp_t;
        reset_dut();
        ibus_inflight = 1;
        drive_redirect(64'h1234_5678_9abc_def0);
        exp_q.push_back(64'h1234_5678_9abc_def0);
        @(negedge clk);
        n_checks++;
        if ({flush_id, flush_ex, fetch_kill, pc_load} !== 4'b1100)
            $display("FAIL redir_fly_accept got %b exp 1100", {flush_id, flush_ex, fetch_kill, pc_load});
        else n_pass++;
        drain_cycles = 0;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            ex_redirect = 0; ex_valid = 0;
            ibus_data_ok = (c == 3);
            @(negedge clk);
            if (dbg_state === DRAIN && flush_id === 1'b1 && pc_load === 1'b0) drain_cycles++;
            if (c == 3) begin
                n_checks++;
                if (fetch_kill !== 1'b1) $display("FAIL redir_fly_kill got %b exp 1", fetch_kill);
                else n_pass++;
            end
        end
        n_checks++;
        if (drain_cycles != 3) $display("FAIL redir_fly_drain got %0d cycles exp 3", drain_cycles);
        else n_pass++;
        next_cycle();
        idle_inputs();
        wait_cycles = 0;
        @(negedge clk);
        while (pc_load !== 1'b1 && wait_cycles < 8) begin
            @(negedge clk);
            wait_cycles++;
        end
        n_checks++;
        if (pc_load !== 1'b1 || wait_cycles != 0)
            $display("FAIL redir_fly_pc_load got extra_wait=%0d exp 0", wait_cycles);
        else begin
            exp_t = exp_q.pop_front();
            if (pc_target !== exp_t) $display("FAIL redir_fly_target got %h exp %h", pc_target, exp_t);
            else n_pass++;
        end
    endtask

    task automatic test_drain_overwrite();
        logic [XLEN-1:0] exp_t;
        reset_dut();
        ibus_inflight = 1;
        drive_redirect(64'hAAAA_0000_0000_0040);
        exp_q.push_back(64'hAAAA_0000_0000_0040);
        next_cycle();
        drive_redirect(64'hBBBB_0000_0000_0080);  // second redirect while draining
        exp_q[exp_q.size()-1] = 64'hBBBB_0000_0000_0080;
        next_cycle();
        ex_redirect = 0; ex_valid = 0; ibus_data_ok = 1;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (pc_load !== 1'b1) $display("FAIL drain_ovw_pc_load got %b exp 1", pc_load);
        else begin
            exp_t = exp_q.pop_front();
            if (pc_target !== exp_t || redirect_cnt !== 2)
                $display("FAIL drain_ovw_target got %h cnt=%0d exp %h cnt=2", pc_target, redirect_cnt, exp_t);
            else n_pass++;
        end
    endtask

    task automatic test_dbus_wait();
        int busy_ok;
        logic [XLEN-1:0] exp_t;
        reset_dut();
        dbus_busy = 1;
        drive_redirect(64'h0000_0000_0000_2000);
        busy_ok = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if ({hold_if, hold_id, hold_ex, hold_mem, bubble_wb} === 5'b11111 &&
                {flush_id, flush_ex, pc_load} === 3'b000) busy_ok++;
            next_cycle();
        end
        n_checks++;
        if (busy_ok != 4) $display("FAIL dbus_hold got %0d good cycles exp 4", busy_ok);
        else n_pass++;
        dbus_busy = 0;
        exp_q.push_back(64'h0000_0000_0000_2000);
        @(negedge clk);
        n_checks++;
        if ({flush_id, flush_ex, hold_if} !== 3'b110 || stall_cnt !== 4)
            $display("FAIL dbus_release got flush=%b%b hold_if=%b stall=%0d exp 1/1/0 stall=4",
                     flush_id, flush_ex, hold_if, stall_cnt);
        else n_pass++;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (pc_load !== 1'b1 || redirect_cnt !== 1) $display("FAIL dbus_pc_load got %b cnt=%0d exp 1 cnt=1", pc_load, redirect_cnt);
        else begin
            exp_t = exp_q.pop_front();
            if (pc_target !== exp_t) $display("FAIL dbus_target got %h exp %h", pc_target, exp_t);
            else n_pass++;
        end
    endtask

    task automatic test_reset_in_drain();
        int loads;
        reset_dut();
        ibus_inflight = 1;
        drive_redirect(64'h0000_0000_0000_3000);
        next_cycle();
        ex_redirect = 0; ex_valid = 0;
        @(negedge clk);
        n_checks++;
        if (dbg_state !== DRAIN) $display("FAIL rst_drain_entry got st=%0d exp DRAIN", dbg_state);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({hold_if, hold_id, hold_ex, hold_mem, flush_id, flush_ex, bubble_wb, fetch_kill, pc_load} !== 9'b0 ||
            stall_cnt !== 0 || redirect_cnt !== 0 || pc_target !== 0 || dbg_state !== RUN)
            $display("FAIL rst_drain_async got outs=%b redir=%0d tgt=%h st=%0d exp 0/0/0/RUN",
                     {hold_if, hold_id, hold_ex, hold_mem, flush_id, flush_ex, bubble_wb, fetch_kill, pc_load},
                     redirect_cnt, pc_target, dbg_state);
        else n_pass++;
        exp_q.delete();
        next_cycle();
        rst = 1'b1;
        ibus_data_ok = 1;
        loads = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (pc_load === 1'b1 || fetch_kill === 1'b1) loads++;
            next_cycle();
            idle_inputs();
        end
        n_checks++;
        if (loads != 0) $display("FAIL rst_drain_no_pc_load got %0d cycles exp 0", loads);
        else n_pass++;
    endtask

    task automatic test_saturation();
        reset_dut();
        force u_dut.stall_cnt_q = 32'hFFFF_FFFF;
        force u_dut.redirect_cnt_q = 32'hFFFF_FFFF;
        #1;
        release u_dut.stall_cnt_q;
        release u_dut.redirect_cnt_q;
        dbus_busy = 1;
        next_cycle();
        n_checks++;
        if (stall_cnt !== 32'hFFFF_FFFF) $display("FAIL stall_sat got %h exp ffffffff", stall_cnt);
        else n_pass++;
        dbus_busy = 0;
        drive_redirect(64'h40);
        next_cycle();
        idle_inputs();
        n_checks++;
        if (redirect_cnt !== 32'hFFFF_FFFF) $display("FAIL redirect_sat got %h exp ffffffff", redirect_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect_idle();
        test_redirect_inflight();
        test_drain_overwrite();
        test_dbus_wait();
        test_reset_in_drain();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the five-stage datapath (fetch, decode, execute, memory, writeback).
- Drives the per-stage bubbleHold inputs, the squash of the IF/ID and ID/EX registers, and the programCounter redirect port (pcIn/pcInEn).
- Handles load-use stalls, data-bus wait stalls and branch/jump redirects, including a redirect that arrives while an instruction fetch is still in flight.

Parameters:
- XLEN, 64, width of PC/target.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- id_valid  in  1  decode stage holds a valid instruction
- id_use_rs1  in  1  decode instruction reads rs1
- id_use_rs2  in  1  decode instruction reads rs2
- id_rs1  in  5  decode rs1 index
- id_rs2  in  5  decode rs2 index
- ex_valid  in  1  execute stage holds a valid instruction
- ex_is_load  in  1  execute instruction is a load
- ex_rd  in  5  execute destination register
- ex_redirect  in  1  execute resolved a taken branch/jump
- ex_target  in  XLEN  redirect target PC
- ibus_inflight  in  1  fetch request issued, response not yet returned
- ibus_data_ok  in  1  fetch response returns this cycle
- dbus_busy  in  1  memory stage waiting on data bus
- hold_if, hold_id, hold_ex, hold_mem  out  1 each  stage bubbleHold
- flush_id  out  1  IF/ID register loads a bubble
- flush_ex  out  1  ID/EX register loads a bubble
- bubble_wb  out  1  MEM/WB register loads a bubble
- fetch_kill  out  1  discard the fetch response returning this cycle
- pc_load  out  1  to pcInEn
- pc_target  out  XLEN  to pcIn
- stall_cnt  out  CNT_W  cycles with any hold asserted
- redirect_cnt  out  CNT_W  accepted redirects

Behaviour:
- Reset (rst=0, async):
  - FSM goes to RUN; target_q=0; both counters 0.
  - All hold/flush/kill/pc_load outputs are 0; pc_target=0.
- FSM has three states: RUN, DRAIN, REDIRECT. pc_target is always target_q.
- Priority within a cycle: dbus wait, then redirect, then load-use.
- dbus wait, any state (dbus_busy=1):
  - hold_if/id/ex/mem=1, bubble_wb=1.
  - ex_redirect is not accepted that cycle; it is re-evaluated when dbus_busy drops.
  - FSM state is frozen.
- Redirect accepted in RUN (ex_redirect & ex_valid & !dbus_busy):
  - target_q<=ex_target; flush_id=1, flush_ex=1 this cycle; redirect_cnt++.
  - Next state: DRAIN if ibus_inflight & !ibus_data_ok, otherwise REDIRECT.
  - If ibus_data_ok=1 in the accept cycle, fetch_kill=1.
- DRAIN:
  - flush_id=1 every cycle.
  - On ibus_data_ok: fetch_kill=1 and go to REDIRECT.
  - A new accepted ex_redirect overwrites target_q (latest wins) and increments redirect_cnt.
- REDIRECT (exactly one cycle):
  - pc_load=1 and flush_id=1, then return to RUN.
  - Total latency from redirect accept to pc_load is 1 cycle with no fetch in flight, else N+1 cycles where N is the cycles until ibus_data_ok.
- Load-use (RUN only, no redirect, no dbus wait):
  - Condition: id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Response: hold_if=1, hold_id=1, flush_ex=1 for one cycle.
  - ex_rd=0 never stalls.
- Counters:
  - stall_cnt increments on any cycle where a hold_* output is 1.
  - Both counters saturate at all-ones and do not wrap.
- Reset mid-DRAIN returns to RUN immediately; no pc_load is issued.
- All outputs are combinational from state plus inputs, except pc_target and the counters, which are registered.

Decomposition:
- Shared package:
  - ctrl_state_t enum {RUN, DRAIN, REDIRECT}.
  - HAZ_CTRL packed struct bundling hold_*/flush_*/bubble_wb for datapath wiring.
- One natural sub-module, hazard_detect: the combinational load-use comparator.

Test Plan:
- Load-use: lw x5 in EX (ex_is_load=1, ex_rd=5), ID reads rs2=5 -> exactly one cycle of hold_if=hold_id=flush_ex=1; ex_rd=0 with id_rs1=0 -> no stall.
- Redirect, idle fetch: ex_redirect=1, ex_target=0x80000100, ibus_inflight=0 -> flush_id/flush_ex same cycle, pc_load=1 with pc_target=0x80000100 next cycle, redirect_cnt=1.
- Redirect with fetch in flight: ibus_data_ok arrives 3 cycles after accept -> DRAIN for 3 cycles, fetch_kill=1 on the data_ok cycle, pc_load on the following cycle.
- dbus_busy held for 4 cycles while ex_redirect=1 -> all holds=1 and bubble_wb=1 for 4 cycles, redirect accepted on the 5th cycle; stall_cnt=4.
- Reset asserted during DRAIN -> all outputs 0 immediately, counters 0, no pc_load after reset release.
- Counter saturation: preload stall_cnt to 0xFFFFFFFF via force, apply a stall -> value stays 0xFFFFFFFF.
